// File: rtl/hazard_scheduler.sv
// Decode-stage sequencing controller: per-register scoreboard of in-flight
// writes (EX/MEM/WB), load-use stall generation, forwarding-source selection
// for both read ports, and a taken-branch flush window FSM.
module hazard_scheduler #(
    parameter int NUM_REGS     = 8,
    parameter int ADDR_W       = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic [ADDR_W-1:0] id_dest,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic [ADDR_W-1:0] r2_address,
    input  logic              id_uses_r1,
    input  logic              id_uses_r2,
    input  logic              branch_taken,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;

    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [NUM_REGS-1:0] load_q, load_d;
    logic [1:0]          age_q [NUM_REGS];
    logic [1:0]          age_d [NUM_REGS];

    logic match_a, match_b, haz_a, haz_b, id_fire;

    // Issue handshake: the decode stage offers an instruction with id_valid;
    // it is accepted (recorded in the scoreboard) only in a cycle where this
    // block raises neither stall nor flush. Nothing is recorded otherwise.
    assign id_fire = id_valid & ~stall & ~flush;

    assign flush = (state_q == ST_FLUSH);
    assign busy  = |pend_q;

    // Source match per read port from registered scoreboard state.
    always_comb begin
        match_a   = id_valid & id_uses_r1 & pend_q[r1_address];
        match_b   = id_valid & id_uses_r2 & pend_q[r2_address];
        haz_a     = match_a & (age_q[r1_address] == 2'd1) & load_q[r1_address];
        haz_b     = match_b & (age_q[r2_address] == 2'd1) & load_q[r2_address];
        fwd_a_sel = 2'd0;
        fwd_b_sel = 2'd0;
        if (match_a && !haz_a && !flush) fwd_a_sel = age_q[r1_address];
        if (match_b && !haz_b && !flush) fwd_b_sel = age_q[r2_address];
        // A flush window overrides any load-use stall.
        stall     = (haz_a | haz_b) & ~flush;
    end

    // Scoreboard next state: new issue overwrites, otherwise pending entries
    // age every cycle (stall does not freeze them) and retire after age 3.
    always_comb begin
        pend_d = pend_q;
        load_d = load_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            age_d[i] = age_q[i];
            if (id_fire && id_reg_write && (id_dest == ADDR_W'(i))) begin
                pend_d[i] = 1'b1;
                age_d[i]  = 2'd1;
                load_d[i] = id_is_load;
            end else if (pend_q[i]) begin
                if (age_q[i] == 2'd3) begin
                    pend_d[i] = 1'b0;
                    age_d[i]  = 2'd0;
                    load_d[i] = 1'b0;
                end else begin
                    age_d[i] = age_q[i] + 2'd1;
                end
            end
        end
    end

    // Flush FSM: counter loaded on entry, leaves FLUSH once it reads 1, so
    // flush stays high for exactly FLUSH_CYCLES cycles. Branches in FLUSH are
    // ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (branch_taken) begin
                    state_d = ST_FLUSH;
                    cnt_d   = 3'(FLUSH_CYCLES);
                end
            end
            ST_FLUSH: begin
                if (cnt_q <= 3'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            pend_q  <= '0;
            load_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) age_q[i] <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            load_q  <= load_d;
            for (int i = 0; i < NUM_REGS; i++) age_q[i] <= age_d[i];
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler with hand-computed expectations.
module tb_hazard_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid, id_reg_write, id_is_load;
    logic [2:0] id_dest, r1_address, r2_address;
    logic       id_uses_r1, id_uses_r2, branch_taken;
    logic       stall, flush, busy;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    int errors = 0;
    int checks = 0;

    hazard_scheduler #(.NUM_REGS(8), .ADDR_W(3), .FLUSH_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .id_dest      (id_dest),
        .r1_address   (r1_address),
        .r2_address   (r2_address),
        .id_uses_r1   (id_uses_r1),
        .id_uses_r2   (id_uses_r2),
        .branch_taken (branch_taken),
        .stall        (stall),
        .flush        (flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .busy         (busy)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic e_stall, input logic e_flush,
                              input logic [1:0] e_a, input logic [1:0] e_b, input logic e_busy);
        check_eq({tag, ".stall"}, {7'd0, stall}, {7'd0, e_stall});
        check_eq({tag, ".flush"}, {7'd0, flush}, {7'd0, e_flush});
        check_eq({tag, ".fwd_a"}, {6'd0, fwd_a_sel}, {6'd0, e_a});
        check_eq({tag, ".fwd_b"}, {6'd0, fwd_b_sel}, {6'd0, e_b});
        check_eq({tag, ".busy"},  {7'd0, busy}, {7'd0, e_busy});
    endtask

    // Drive one decode-stage vector, then settle before checking.
    task automatic drive(input logic v, input logic rw, input logic ld, input logic [2:0] dst,
                         input logic [2:0] a1, input logic [2:0] a2,
                         input logic u1, input logic u2, input logic br);
        id_valid     = v;
        id_reg_write = rw;
        id_is_load   = ld;
        id_dest      = dst;
        r1_address   = a1;
        r2_address   = a2;
        id_uses_r1   = u1;
        id_uses_r2   = u2;
        branch_taken = br;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle();
        #2;
        expect_out("reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ADD r3 then SUB r4,r3,r1 then readers of r3
        drive(1, 1, 0, 3'd3, 0, 0, 0, 0, 0);
        expect_out("add_r3", 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 3'd4, 3'd3, 3'd1, 1, 1, 0);
        expect_out("sub_r4", 0, 0, 1, 0, 1);
        tick();
        drive(1, 0, 0, 0, 3'd3, 0, 1, 0, 0);
        expect_out("rd_r3_age2", 0, 0, 2, 0, 1);
        tick();
        drive(1, 0, 0, 0, 3'd3, 0, 1, 0, 0);
        expect_out("rd_r3_age3", 0, 0, 3, 0, 1);
        tick();
        drive(1, 0, 0, 0, 3'd3, 3'd4, 1, 1, 0);
        expect_out("rd_r3_gone", 0, 0, 0, 3, 1);
        tick();
        idle();
        expect_out("drained1", 0, 0, 0, 0, 0);
        tick();

        // LDM r2 then ADD r5,r2,r2: one stall cycle then sel=2 on both ports
        drive(1, 1, 1, 3'd2, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 3'd5, 3'd2, 3'd2, 1, 1, 0);
        expect_out("load_use", 1, 0, 0, 0, 1);
        tick();
        expect_out("load_use_res", 0, 0, 2, 2, 1);
        tick();
        idle();
        expect_out("after_ld", 0, 0, 0, 0, 1);
        tick(); tick(); tick();
        expect_out("drained2", 0, 0, 0, 0, 0);

        // ADD r1 twice: newest producer wins
        drive(1, 1, 0, 3'd1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 3'd1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 3'd1, 3'd1, 1, 1, 0);
        expect_out("ovw_age1", 0, 0, 1, 1, 1);
        tick();
        expect_out("ovw_age2", 0, 0, 2, 2, 1);
        tick();
        idle();
        tick(); tick();
        expect_out("drained3", 0, 0, 0, 0, 0);

        // Branch flush window; second branch ignored; writes not recorded
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        expect_out("br_pulse", 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 3'd7, 3'd7, 0, 1, 0, 1);
        expect_out("flush_c1", 0, 1, 0, 0, 0);
        tick();
        drive(1, 1, 0, 3'd7, 3'd7, 0, 1, 0, 0);
        expect_out("flush_c2", 0, 1, 0, 0, 0);
        tick();
        idle();
        expect_out("flush_end", 0, 0, 0, 0, 0);
        tick();

        // Reset mid-flush with r6 pending at age 1
        drive(1, 1, 0, 3'd6, 0, 0, 0, 0, 1);
        expect_out("r6_and_br", 0, 0, 0, 0, 0);
        tick();
        idle();
        expect_out("mid_flush", 0, 1, 0, 0, 1);
        rst = 1'b1;
        #1;
        expect_out("async_rst", 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        drive(1, 0, 0, 0, 3'd6, 0, 1, 0, 0);
        expect_out("rd_r6_post", 0, 0, 0, 0, 0);
        tick();

        // Load-use hazard coinciding with a branch
        drive(1, 1, 1, 3'd2, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 3'd2, 0, 1, 0, 1);
        expect_out("lu_br", 1, 0, 0, 0, 1);
        tick();
        drive(1, 0, 0, 0, 3'd2, 0, 1, 0, 0);
        expect_out("lu_br_f1", 0, 1, 0, 0, 1);
        tick();
        expect_out("lu_br_f2", 0, 1, 0, 0, 1);
        tick();
        expect_out("lu_br_end", 0, 0, 0, 0, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Pipeline sequencing controller for the decode stage. It drives the decode-stage stall input and the IF/ID flush.
- A per-register scoreboard tracks in-flight register writes through EX/MEM/WB. It detects load-use hazards and chooses the forwarding source for both register-file read ports.
- An FSM handles taken-branch flush windows.
- Sits beside the decode stage and consumes the decoded dest, source-address and control fields.

Parameters:
- NUM_REGS, 8, number of architectural registers; must equal 2**ADDR_W.
- ADDR_W, 3, register address width.
- FLUSH_CYCLES, 2, cycles that flush stays asserted after a taken branch; legal range 1..7.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- id_valid  input  1  decode stage holds a real instruction.
- id_reg_write  input  1  decoded instruction writes a register.
- id_is_load  input  1  decoded instruction is a load (LDM).
- id_dest  input  ADDR_W  destination register of the decoded instruction.
- r1_address  input  ADDR_W  read port 1 address.
- r2_address  input  ADDR_W  read port 2 address, taken after the R2 select mux.
- id_uses_r1  input  1  decoded instruction consumes port 1.
- id_uses_r2  input  1  decoded instruction consumes port 2.
- branch_taken  input  1  one-cycle pulse from EX: redirect taken.
- stall  output  1  hold PC and IF/ID; inject a bubble into EX.
- flush  output  1  kill the IF/ID contents.
- fwd_a_sel  output  2  port 1 operand source: 0 = regfile, 1 = EX/MEM result, 2 = MEM/WB result, 3 = WB write-data bypass.
- fwd_b_sel  output  2  port 2 operand source; same encoding as fwd_a_sel.
- busy  output  1  at least one scoreboard entry is pending.

Behaviour:
- Reset (async): all scoreboard entries cleared, FSM in IDLE, flush counter 0. Outputs: stall=0, flush=0, fwd_a_sel=0, fwd_b_sel=0, busy=0.
- Scoreboard entry per register: pending, age[1:0], load.
- Issue: id_fire = id_valid & ~stall & ~flush.
  - On id_fire with id_reg_write, entry[id_dest] loads {pending=1, age=1, load=id_is_load} at the next edge.
- Aging: every cycle, every pending entry not being reloaded increments age, regardless of stall (stall only freezes IF/ID).
  - An entry at age 3 clears at the next edge.
  - A new issue to the same register overwrites the entry; the newest producer wins.
- Source match, evaluated per port combinationally from registered state: match = id_valid & id_uses_rN & entry[rN_address].pending.
  - age 1 & ~load: sel = 1.
  - age 1 & load: hazard, sel = 0.
  - age 2: sel = 2.
  - age 3: sel = 3.
  - No match: sel = 0.
- Load-use stall: stall = hazard on either port & ~flush. It is combinational, with no added latency.
  - A stalled load-use resolves after exactly one stall cycle: the producer is then at age 2 and sel = 2.
- Both ports may match different entries; each port is selected independently.
- r1_address == r2_address: both ports receive the same sel.
- FSM states:
  - IDLE: branch_taken goes to FLUSH and loads the counter with FLUSH_CYCLES. flush is asserted starting the cycle after the pulse.
  - FLUSH: flush = 1 and the counter decrements each cycle. Return to IDLE when the counter reaches 1, so flush is high for exactly FLUSH_CYCLES cycles.
  - branch_taken while in FLUSH is ignored.
- Flush priority: while flush = 1, stall = 0, no issue is recorded, fwd selects are 0, and in-flight entries keep aging normally.
- branch_taken in the same cycle as a load-use hazard: stall is still computed for that cycle; flush begins the next cycle.
- Reset mid-flush or mid-stall aborts immediately to the reset state.
- busy = OR of all pending bits.

Test Plan:
- ADD r3 issued, then SUB r4,r3,r1 in the next cycle → fwd_a_sel=1, stall=0. A third instruction reading r3 one cycle later gets sel=2, then sel=3, then sel=0.
- LDM r2 issued, then ADD r5,r2,r2 → stall=1 for exactly 1 cycle; the following cycle fwd_a_sel=fwd_b_sel=2 and stall=0.
- ADD r1 then ADD r1 (overwrite), then a reader of r1 → sel=1, tracking the newer producer; the older entry does not produce sel=2.
- branch_taken pulse with FLUSH_CYCLES=2 → flush=1 for 2 cycles starting the next cycle, stall=0, id_valid writes during that window are not recorded. A second branch_taken during the window is ignored.
- rst asserted mid-flush with r6 pending at age 1 → flush=0, busy=0, stall=0 asynchronously; after release, a reader of r6 gets sel=0.
- Load-use hazard coinciding with a branch_taken pulse → stall=1 that cycle, then flush=1 and stall=0 for FLUSH_CYCLES cycles.
